fetch_ctrl: RTL and testbench

- Sequencing controller for the instruction-fetch PC and the instruction-memory request.
- Owns ice/iaddr generation: boot delay after reset, sequential PC+4, branch/jump redirect with MIPS delay-slot semantics, and exception flush redirect.
- Handles hazard-unit stalls and instruction-memory wait states.
- Sits between the hazard/branch/exception logic and the instruction memory; feeds the IF/ID register.

---
 rtl/fetch_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_fetch_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
// Sequencing controller for the instruction-fetch PC and the instruction-memory
// request. It generates ice/iaddr: a boot delay after reset, sequential PC+4,
// branch/jump redirect with MIPS delay-slot semantics, and exception flush
// redirect. It also handles hazard stalls and instruction-memory wait states,
// and feeds the IF/ID register through pc/inst_valid_o.
//
// Optional feature macro: FETCH_ALIGN_CHECK_EN
//   defined   : adds adel_o. A misaligned branch target is ignored, so fetch
//               stays sequential, and adel_o pulses for one cycle.
//   undefined : no adel_o. Target bits [1:0] are forced to zero on iaddr.
//
// Ports:
//   cpu_clk_50M   in   1   clock, rising edge
//   cpu_rst_n     in   1   asynchronous active-low reset
//   stall_i       in   1   hazard unit: hold fetch
//   br_taken_i    in   1   branch/jump taken (one-cycle pulse)
//   br_target_i   in  32   branch/jump target
//   flush_i       in   1   exception flush (one-cycle pulse)
//   flush_pc_i    in  32   exception handler address
//   imem_ready_i  in   1   memory accepts the request presented this cycle
//   ice           out  1   instruction memory request valid
//   iaddr         out 32   instruction memory address
//   pc            out 32   address of the instruction flagged by inst_valid_o
//   inst_valid_o  out  1   instruction accepted last cycle is live
//   adel_o        out  1   misaligned redirect (FETCH_ALIGN_CHECK_EN only)
// -----------------------------------------------------------------------------
module fetch_ctrl #(
  parameter logic [31:0] PC_INIT     = 32'h0000_0000,
  parameter int unsigned RESET_DELAY = 1
) (
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst_n,
  input  logic        stall_i,
  input  logic        br_taken_i,
  input  logic [31:0] br_target_i,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  input  logic        imem_ready_i,
  output logic        ice,
  output logic [31:0] iaddr,
  output logic [31:0] pc,
  output logic        inst_valid_o
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic        adel_o
`endif
);

  typedef enum logic [1:0] {
    S_BOOT,
    S_FETCH,
    S_WAIT,
    S_STALL
  } state_t;

  state_t      state;
  logic [3:0]  boot_cnt;

  // Redirect that arrived while no request was being accepted.
  logic        pend_valid;
  logic        pend_flush;
  logic [31:0] pend_addr;

  logic        br_ok;
  logic [31:0] br_addr;
  logic [31:0] flush_addr;
  logic        redir_valid;
  logic [31:0] redir_addr;
  logic        pend_valid_n;
  logic        pend_flush_n;
  logic [31:0] pend_addr_n;
  logic        squash;
  logic [31:0] seq_addr;

`ifdef FETCH_ALIGN_CHECK_EN
  logic        br_misaligned;

  // A misaligned branch target is dropped. The exception handler address is
  // trusted as given.
  always_comb begin
    br_misaligned = br_taken_i && (br_target_i[1:0] != 2'b00);
    br_ok         = br_taken_i && !br_misaligned;
    br_addr       = br_target_i;
    flush_addr    = flush_pc_i;
  end
`else
  // Without the check, targets are taken as given but forced word-aligned.
  always_comb begin
    br_ok      = br_taken_i;
    br_addr    = br_target_i & 32'hFFFF_FFFC;
    flush_addr = flush_pc_i & 32'hFFFF_FFFC;
  end
`endif

  // Resolve which redirect, if any, replaces the sequential address.
  // Priority: a live flush, then a pending flush, then a live branch, then a
  // pending branch. A branch must never override an outstanding flush.
  always_comb begin
    redir_valid = 1'b0;
    redir_addr  = iaddr;
    if (flush_i) begin
      redir_valid = 1'b1;
      redir_addr  = flush_addr;
    end else if (pend_valid && pend_flush) begin
      redir_valid = 1'b1;
      redir_addr  = pend_addr;
    end else if (br_ok) begin
      redir_valid = 1'b1;
      redir_addr  = br_addr;
    end else if (pend_valid) begin
      redir_valid = 1'b1;
      redir_addr  = pend_addr;
    end
  end

  // Next value of the pending register when no request is accepted this edge.
  // A flush overwrites a pending branch, but a branch never replaces a flush.
  always_comb begin
    pend_valid_n = pend_valid;
    pend_flush_n = pend_flush;
    pend_addr_n  = pend_addr;
    if (flush_i) begin
      pend_valid_n = 1'b1;
      pend_flush_n = 1'b1;
      pend_addr_n  = flush_addr;
    end else if (br_ok && !(pend_valid && pend_flush)) begin
      pend_valid_n = 1'b1;
      pend_flush_n = 1'b0;
      pend_addr_n  = br_addr;
    end
  end

  // The instruction accepted alongside a flush, or while one is pending,
  // belongs to the abandoned stream.
  assign squash   = flush_i || (pend_valid && pend_flush);
  assign seq_addr = iaddr + 32'd4;

  // Main sequencer. It registers ice/iaddr toward memory and pc/inst_valid_o
  // toward IF/ID. ice is high only in FETCH and WAIT, so acceptance can only
  // happen in those states.
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state        <= S_BOOT;
      boot_cnt     <= 4'd0;
      ice          <= 1'b0;
      iaddr        <= PC_INIT;
      pc           <= PC_INIT;
      inst_valid_o <= 1'b0;
      pend_valid   <= 1'b0;
      pend_flush   <= 1'b0;
      pend_addr    <= 32'd0;
`ifdef FETCH_ALIGN_CHECK_EN
      adel_o       <= 1'b0;
`endif
    end else begin
      inst_valid_o <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      adel_o       <= (state != S_BOOT) && br_misaligned;
`endif
      case (state)
        S_BOOT: begin
          if (boot_cnt == 4'(RESET_DELAY - 1)) begin
            state <= S_FETCH;
            ice   <= 1'b1;
            iaddr <= PC_INIT;
          end else begin
            boot_cnt <= boot_cnt + 4'd1;
          end
        end

        S_FETCH, S_WAIT: begin
          if (imem_ready_i) begin
            iaddr      <= redir_valid ? redir_addr : seq_addr;
            pend_valid <= 1'b0;
            pend_flush <= 1'b0;
            if (!squash) begin
              inst_valid_o <= 1'b1;
              pc           <= iaddr;
            end
            // A stall seen during a wait only bites once the request is done.
            if (stall_i) begin
              state <= S_STALL;
              ice   <= 1'b0;
            end else begin
              state <= S_FETCH;
            end
          end else begin
            // iaddr must stay stable until acceptance, so redirects are parked.
            pend_valid <= pend_valid_n;
            pend_flush <= pend_flush_n;
            pend_addr  <= pend_addr_n;
            if ((state == S_FETCH) && stall_i) begin
              state <= S_STALL;
              ice   <= 1'b0;
            end else begin
              state <= S_WAIT;
            end
          end
        end

        S_STALL: begin
          if (stall_i) begin
            pend_valid <= pend_valid_n;
            pend_flush <= pend_flush_n;
            pend_addr  <= pend_addr_n;
          end else begin
            // ice is low here, so a parked redirect can be applied directly
            // to the next request rather than waiting for an acceptance.
            state      <= S_FETCH;
            ice        <= 1'b1;
            pend_valid <= 1'b0;
            pend_flush <= 1'b0;
            if (redir_valid) begin
              iaddr <= redir_addr;
            end
          end
        end

        default: begin
          state <= S_BOOT;
          ice   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl
// Self-checking bench for fetch_ctrl in its default build. A table of per-cycle
// vectors drives stimulus. Each applied vector pushes its expected registered
// outputs onto a scoreboard queue, and these are popped and compared one cycle
// later. Hand-written sequences cover reset values and asynchronous reset in
// the middle of a wait state.
// -----------------------------------------------------------------------------
module tb_fetch_ctrl;

  logic        cpu_clk_50M;
  logic        cpu_rst_n;
  logic        stall_i;
  logic        br_taken_i;
  logic [31:0] br_target_i;
  logic        flush_i;
  logic [31:0] flush_pc_i;
  logic        imem_ready_i;
  logic        ice;
  logic [31:0] iaddr;
  logic [31:0] pc;
  logic        inst_valid_o;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        adel_o;
`endif

  // ctl = {stall_i, br_taken_i, flush_i, imem_ready_i}
  typedef struct {
    logic [3:0]  ctl;
    logic [31:0] bt;
    logic [31:0] fp;
    logic        e_ice;
    logic [31:0] e_iaddr;
    logic        e_valid;
    logic [31:0] e_pc;
  } vec_t;

  typedef struct {
    logic        ice;
    logic [31:0] iaddr;
    logic        valid;
    logic [31:0] pc;
  } exp_t;

  vec_t tbl [27];
  exp_t sb [$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  fetch_ctrl dut (
    .cpu_clk_50M  (cpu_clk_50M),
    .cpu_rst_n    (cpu_rst_n),
    .stall_i      (stall_i),
    .br_taken_i   (br_taken_i),
    .br_target_i  (br_target_i),
    .flush_i      (flush_i),
    .flush_pc_i   (flush_pc_i),
    .imem_ready_i (imem_ready_i),
    .ice          (ice),
    .iaddr        (iaddr),
    .pc           (pc),
    .inst_valid_o (inst_valid_o)
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    .adel_o       (adel_o)
`endif
  );

  // 50 MHz clock.
  initial begin
    cpu_clk_50M = 1'b0;
    forever #10 cpu_clk_50M = ~cpu_clk_50M;
  end

  // Global time bound so the bench cannot hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check1(input string name, input logic [31:0] got, input logic [31:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    {stall_i, br_taken_i, flush_i, imem_ready_i} = v.ctl;
    br_target_i = v.bt;
    flush_pc_i  = v.fp;
    e.ice   = v.e_ice;
    e.iaddr = v.e_iaddr;
    e.valid = v.e_valid;
    e.pc    = v.e_pc;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input int row);
    exp_t e;
    if (sb.size() == 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL row%0d scoreboard: got empty expected entry", row);
    end else begin
      e = sb.pop_front();
      check1($sformatf("row%0d ice", row),   {31'd0, ice},          {31'd0, e.ice});
      check1($sformatf("row%0d iaddr", row), iaddr,                 e.iaddr);
      check1($sformatf("row%0d valid", row), {31'd0, inst_valid_o}, {31'd0, e.valid});
      check1($sformatf("row%0d pc", row),    pc,                    e.pc);
    end
  endtask

  task automatic checkReset(input string tag);
    check1({tag, " ice"},   {31'd0, ice},          32'd0);
    check1({tag, " iaddr"}, iaddr,                 32'd0);
    check1({tag, " pc"},    pc,                    32'd0);
    check1({tag, " valid"}, {31'd0, inst_valid_o}, 32'd0);
  endtask

  task automatic runRows(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      applyStimulus(tbl[i]);
      @(posedge cpu_clk_50M);
      #1;
      checkOutput(i);
      @(negedge cpu_clk_50M);
    end
  endtask

  initial begin
    // Boot and sequential fetch with wait states at 0x8.
    tbl[0]  = '{4'b0001, 32'h0, 32'h0, 1'b1, 32'h0000_0000, 1'b0, 32'h0000_0000};
    tbl[1]  = '{4'b0001, 32'h0, 32'h0, 1'b1, 32'h0000_0004, 1'b1, 32'h0000_0000};
    tbl[2]  = '{4'b0001, 32'h0, 32'h0, 1'b1, 32'h0000_0008, 1'b1, 32'h0000_0004};
    tbl[3]  = '{4'b0000, 32'h0, 32'h0, 1'b1, 32'h0000_0008, 1'b0, 32'h0000_0004};
    tbl[4]  = '{4'b0000, 32'h0, 32'h0, 1'b1, 32'h0000_0008, 1'b0, 32'h0000_0004};
    tbl[5]  = '{4'b0001, 32'h0, 32'h0, 1'b1, 32'h0000_000C, 1'b1, 32'h0000_0008};
    tbl[6]  = '{4'b0001, 32'h0, 32'h0, 1'b1, 32'h0000_0010, 1'b1, 32'h0000_000C};
    // Branch on the edge accepting 0x10: delay slot 0x10 stays valid.
    tbl[7]  = '{4'b0101, 32'h100, 32'h0, 1'b1, 32'h0000_0100, 1'b1, 32'h0000_0010};
    tbl[8]  = '{4'b0001, 32'h0, 32'h0, 1'b1, 32'h0000_0104, 1'b1, 32'h0000_0100};
    tbl[9]  = '{4'b0101, 32'h20, 32'h0, 1'b1, 32'h0000_0020, 1'b1, 32'h0000_0104};
    // Flush while 0x20 waits; the later branch must not override it.
    tbl[10] = '{4'b0010, 32'h0, 32'h380, 1'b1, 32'h0000_0020, 1'b0, 32'h0000_0104};
    tbl[11] = '{4'b0101, 32'h500, 32'h0, 1'b1, 32'h0000_0380, 1'b0, 32'h0000_0104};
    tbl[12] = '{4'b0001, 32'h0, 32'h0, 1'b1, 32'h0000_0384, 1'b1, 32'h0000_0380};
    // Three-cycle stall with a branch to 0x40 mid-stall.
    tbl[13] = '{4'b1000, 32'h0, 32'h0, 1'b0, 32'h0000_0384, 1'b0, 32'h0000_0380};
    tbl[14] = '{4'b1100, 32'h40, 32'h0, 1'b0, 32'h0000_0384, 1'b0, 32'h0000_0380};
    tbl[15] = '{4'b1000, 32'h0, 32'h0, 1'b0, 32'h0000_0384, 1'b0, 32'h0000_0380};
    tbl[16] = '{4'b0000, 32'h0, 32'h0, 1'b1, 32'h0000_0040, 1'b0, 32'h0000_0380};
    tbl[17] = '{4'b0001, 32'h0, 32'h0, 1'b1, 32'h0000_0044, 1'b1, 32'h0000_0040};
    // Wrap-around from the top of the address space.
    tbl[18] = '{4'b0101, 32'hFFFF_FFFC, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h0000_0044};
    tbl[19] = '{4'b0001, 32'h0, 32'h0, 1'b1, 32'h0000_0000, 1'b1, 32'hFFFF_FFFC};
    // Enter WAIT with a parked branch; an async reset follows.
    tbl[20] = '{4'b0100, 32'h700, 32'h0, 1'b1, 32'h0000_0000, 1'b0, 32'hFFFF_FFFC};
    // After reset: parked branch gone, same-edge flush squash, target masking.
    tbl[21] = '{4'b0001, 32'h0, 32'h0, 1'b1, 32'h0000_0000, 1'b0, 32'h0000_0000};
    tbl[22] = '{4'b0001, 32'h0, 32'h0, 1'b1, 32'h0000_0004, 1'b1, 32'h0000_0000};
    tbl[23] = '{4'b0011, 32'h0, 32'h200, 1'b1, 32'h0000_0200, 1'b0, 32'h0000_0000};
    tbl[24] = '{4'b0001, 32'h0, 32'h0, 1'b1, 32'h0000_0204, 1'b1, 32'h0000_0200};
    tbl[25] = '{4'b0101, 32'h303, 32'h0, 1'b1, 32'h0000_0300, 1'b1, 32'h0000_0204};
    tbl[26] = '{4'b0001, 32'h0, 32'h0, 1'b1, 32'h0000_0304, 1'b1, 32'h0000_0300};

    cpu_rst_n    = 1'b0;
    stall_i      = 1'b0;
    br_taken_i   = 1'b0;
    br_target_i  = 32'd0;
    flush_i      = 1'b0;
    flush_pc_i   = 32'd0;
    imem_ready_i = 1'b1;

    $display("[TB] holding reset for 3 cycles");
    repeat (3) @(posedge cpu_clk_50M);
    @(negedge cpu_clk_50M);
    checkReset("reset");
    cpu_rst_n = 1'b1;
    #1;
    check1("boot ice", {31'd0, ice}, 32'd0);

    runRows(0, 20);

    // Asynchronous reset in the middle of a wait, away from any clock edge.
    $display("[TB] asserting async reset mid-WAIT");
    stall_i    = 1'b0;
    br_taken_i = 1'b0;
    flush_i    = 1'b0;
    #3;
    cpu_rst_n = 1'b0;
    #1;
    checkReset("async reset");
    repeat (2) @(negedge cpu_clk_50M);
    cpu_rst_n = 1'b1;

    runRows(21, 26);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
